// File: rtl/program_memory_loader_if.sv
// ---------------------------------------------------------------------------
// program_memory_loader_if
// Groups the byte-stream handshake and the program-RAM write port of the
// boot loader.
//   ByteData/ByteValid : byte stream from the host (serial bridge)
//   ByteReady          : loader can take a byte this cycle
//   MemWrite           : one-cycle write strobe to program RAM
//   MemAddress         : byte address of the word written (multiple of 4)
//   MemWriteData       : 32-bit instruction word written
// Modports: master = host / bench side, slave = loader side.
// ---------------------------------------------------------------------------
interface program_memory_loader_if;
    logic [7:0]  ByteData;
    logic        ByteValid;
    logic        ByteReady;
    logic        MemWrite;
    logic [31:0] MemAddress;
    logic [31:0] MemWriteData;

    modport master (
        output ByteData,
        output ByteValid,
        input  ByteReady,
        input  MemWrite,
        input  MemAddress,
        input  MemWriteData
    );

    modport slave (
        input  ByteData,
        input  ByteValid,
        output ByteReady,
        output MemWrite,
        output MemAddress,
        output MemWriteData
    );
endinterface

// File: rtl/program_memory_loader.sv
// ---------------------------------------------------------------------------
// program_memory_loader
// Boot-time loader: receives header N, 4*N big-endian data bytes and one
// checksum byte, writes N 32-bit words into program RAM and releases the
// processor only after a complete image with an 8-bit zero-sum checksum.
// Ports:
//   clk          : system clock
//   reset        : asynchronous active-low reset
//   Start        : single-cycle pulse, restarts a load from any state
//   bus          : byte stream handshake + program RAM write port (slave)
//   ProcessorRun : high only in DONE (processor's active-low reset)
//   Busy         : high in HEADER, DATA, WRITE, CHECK
//   Done         : high in DONE
//   Error        : high in ERROR
//   WordsLoaded  : words written in the current load
// ---------------------------------------------------------------------------
module program_memory_loader #(
    parameter int MEMORY_DEPTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    Start,
    program_memory_loader_if.slave  bus,
    output logic                    ProcessorRun,
    output logic                    Busy,
    output logic                    Done,
    output logic                    Error,
    output logic [7:0]              WordsLoaded
);

    localparam logic [7:0] DEPTH_B = 8'(MEMORY_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HEADER = 3'd1,
        S_DATA   = 3'd2,
        S_WRITE  = 3'd3,
        S_CHECK  = 3'd4,
        S_DONE   = 3'd5,
        S_ERROR  = 3'd6
    } state_t;

    state_t      r_state;
    logic [7:0]  r_sum;
    logic [1:0]  r_byte_cnt;
    logic [7:0]  r_word_idx;
    logic [7:0]  r_n;
    logic [23:0] r_shift;
    logic        r_ready;
    logic        r_busy;
    logic        r_done;
    logic        r_error;
    logic        r_run;
    logic        r_mem_write;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_data;

    logic        w_accept;
    logic [7:0]  w_sum_next;
    logic [7:0]  w_idx_next;

    // Start masks ByteReady in its own cycle so a restart never swallows a byte.
    assign bus.ByteReady    = r_ready & ~Start;
    assign w_accept         = bus.ByteValid & bus.ByteReady;
    assign w_sum_next       = r_sum + bus.ByteData;
    assign w_idx_next       = r_word_idx + 8'd1;

    assign bus.MemWrite     = r_mem_write;
    assign bus.MemAddress   = r_mem_addr;
    assign bus.MemWriteData = r_mem_data;
    assign ProcessorRun     = r_run;
    assign Busy             = r_busy;
    assign Done             = r_done;
    assign Error            = r_error;
    assign WordsLoaded      = r_word_idx;

    // Loader FSM with registered status/strobe outputs set on each transition.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_sum       <= 8'd0;
            r_byte_cnt  <= 2'd0;
            r_word_idx  <= 8'd0;
            r_n         <= 8'd0;
            r_shift     <= 24'd0;
            r_ready     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_run       <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_data  <= 32'd0;
        end else if (Start) begin
            // Restart: partial word discarded, RAM contents left as they are.
            r_state     <= S_HEADER;
            r_sum       <= 8'd0;
            r_byte_cnt  <= 2'd0;
            r_word_idx  <= 8'd0;
            r_shift     <= 24'd0;
            r_ready     <= 1'b1;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_run       <= 1'b0;
            r_mem_write <= 1'b0;
        end else begin
            r_mem_write <= 1'b0;
            case (r_state)
                S_HEADER: begin
                    if (w_accept) begin
                        r_sum <= w_sum_next;
                        r_n   <= bus.ByteData;
                        if ((bus.ByteData == 8'd0) || (bus.ByteData > DEPTH_B)) begin
                            r_state <= S_ERROR;
                            r_ready <= 1'b0;
                            r_busy  <= 1'b0;
                            r_error <= 1'b1;
                        end else begin
                            r_state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
                        r_sum      <= w_sum_next;
                        r_shift    <= {r_shift[15:0], bus.ByteData};
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            // Fourth byte completes the word: strobe lasts the WRITE cycle.
                            r_state     <= S_WRITE;
                            r_ready     <= 1'b0;
                            r_mem_write <= 1'b1;
                            r_mem_addr  <= {22'd0, r_word_idx, 2'b00};
                            r_mem_data  <= {r_shift, bus.ByteData};
                        end
                    end
                end
                S_WRITE: begin
                    r_word_idx <= w_idx_next;
                    r_ready    <= 1'b1;
                    if (w_idx_next == r_n) begin
                        r_state <= S_CHECK;
                    end else begin
                        r_state <= S_DATA;
                    end
                end
                S_CHECK: begin
                    if (w_accept) begin
                        r_sum   <= w_sum_next;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b0;
                        if (w_sum_next == 8'd0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_run   <= 1'b1;
                        end else begin
                            r_state <= S_ERROR;
                            r_error <= 1'b1;
                        end
                    end
                end
                S_IDLE, S_DONE, S_ERROR: begin
                    r_state <= r_state;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_error <= 1'b0;
                    r_run   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_memory_loader.sv
// ---------------------------------------------------------------------------
// tb_program_memory_loader
// Table-driven cycle check of a gapless load, followed by hand-written
// sequences for bad checksum, bad headers, stalled streams, restart and
// asynchronous reset.
// ---------------------------------------------------------------------------
module tb_program_memory_loader;

    localparam int DEPTH = 32;

    logic       clk;
    logic       reset;
    logic       Start;
    logic       ProcessorRun;
    logic       Busy;
    logic       Done;
    logic       Error;
    logic [7:0] WordsLoaded;

    program_memory_loader_if bus ();

    program_memory_loader #(.MEMORY_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .Start        (Start),
        .bus          (bus),
        .ProcessorRun (ProcessorRun),
        .Busy         (Busy),
        .Done         (Done),
        .Error        (Error),
        .WordsLoaded  (WordsLoaded)
    );

    typedef struct {
        logic        start;
        logic        valid;
        logic [7:0]  data;
        logic [77:0] exp;
    } vec_t;

    vec_t        tbl [14];
    logic [7:0]  s_good [10];
    logic [7:0]  s_bad  [10];
    logic [31:0] exp_a  [2];
    logic [31:0] exp_d  [2];
    logic [31:0] wr_addr [$];
    logic [31:0] wr_data [$];
    int          checks   = 0;
    int          failures = 0;
    int          xfers    = 0;
    int          x0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Count byte transfers on each rising edge.
    always @(posedge clk) begin
        if (bus.ByteValid === 1'b1 && bus.ByteReady === 1'b1) xfers <= xfers + 1;
    end

    // Log RAM writes mid-cycle while the strobe is stable.
    always @(negedge clk) begin
        if (bus.MemWrite === 1'b1) begin
            wr_addr.push_back(bus.MemAddress);
            wr_data.push_back(bus.MemWriteData);
        end
    end

    function automatic logic [77:0] mk(input logic rdy, input logic mw, input logic busy,
                                       input logic done, input logic err, input logic run,
                                       input logic [7:0] w, input logic [31:0] a,
                                       input logic [31:0] d);
        return {rdy, mw, busy, done, err, run, w, a, d};
    endfunction

    function automatic logic [77:0] outs();
        return {bus.ByteReady, bus.MemWrite, Busy, Done, Error, ProcessorRun,
                WordsLoaded, bus.MemAddress, bus.MemWriteData};
    endfunction

    task automatic check(input string name, input logic [77:0] act, input logic [77:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.ByteValid = 1'b0;
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        Start         = 1'b1;
        bus.ByteValid = 1'b0;
        @(posedge clk);
        #1;
        Start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit got;
        got = 1'b0;
        @(negedge clk);
        Start         = 1'b0;
        bus.ByteData  = b;
        bus.ByteValid = 1'b1;
        for (int k = 0; k < 20 && !got; k++) begin
            #1;
            if (bus.ByteReady === 1'b1) got = 1'b1;
            @(posedge clk);
            if (!got) @(negedge clk);
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL send_byte_timeout: byte %h never accepted", b);
        end
    endtask

    task automatic send_stream(input logic [7:0] s [10], input bit gaps);
        for (int i = 0; i < 10; i++) begin
            // No gap before the byte that follows a WRITE: ByteValid stays high across it.
            if (gaps && i != 5 && i != 9) idle($urandom_range(0, 2));
            send_byte(s[i]);
        end
    endtask

    task automatic check_log(input string tag);
        check({tag, "_nwrites"}, 78'(wr_addr.size()), 78'(2));
        for (int i = 0; i < wr_addr.size() && i < 2; i++) begin
            check({tag, "_addr"}, 78'(wr_addr[i]), 78'(exp_a[i]));
            check({tag, "_data"}, 78'(wr_data[i]), 78'(exp_d[i]));
        end
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
    endtask

    initial begin
        s_good = '{8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h34, 8'h09, 8'h00, 8'h0F, 8'h85};
        s_bad  = '{8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h34, 8'h09, 8'h00, 8'h0F, 8'h84};
        exp_a  = '{32'h0000_0000, 32'h0000_0004};
        exp_d  = '{32'h2008_0005, 32'h3409_000F};

        tbl[0]  = '{1'b1, 1'b0, 8'h00, mk(0,0,0,0,0,0,8'd0,32'h0,32'h0)};
        tbl[1]  = '{1'b0, 1'b1, 8'h02, mk(1,0,1,0,0,0,8'd0,32'h0,32'h0)};
        tbl[2]  = '{1'b0, 1'b1, 8'h20, mk(1,0,1,0,0,0,8'd0,32'h0,32'h0)};
        tbl[3]  = '{1'b0, 1'b1, 8'h08, mk(1,0,1,0,0,0,8'd0,32'h0,32'h0)};
        tbl[4]  = '{1'b0, 1'b1, 8'h00, mk(1,0,1,0,0,0,8'd0,32'h0,32'h0)};
        tbl[5]  = '{1'b0, 1'b1, 8'h05, mk(1,0,1,0,0,0,8'd0,32'h0,32'h0)};
        tbl[6]  = '{1'b0, 1'b1, 8'h34, mk(0,1,1,0,0,0,8'd0,32'h0,32'h2008_0005)};
        tbl[7]  = '{1'b0, 1'b1, 8'h34, mk(1,0,1,0,0,0,8'd1,32'h0,32'h2008_0005)};
        tbl[8]  = '{1'b0, 1'b1, 8'h09, mk(1,0,1,0,0,0,8'd1,32'h0,32'h2008_0005)};
        tbl[9]  = '{1'b0, 1'b1, 8'h00, mk(1,0,1,0,0,0,8'd1,32'h0,32'h2008_0005)};
        tbl[10] = '{1'b0, 1'b1, 8'h0F, mk(1,0,1,0,0,0,8'd1,32'h0,32'h2008_0005)};
        tbl[11] = '{1'b0, 1'b1, 8'h85, mk(0,1,1,0,0,0,8'd1,32'h4,32'h3409_000F)};
        tbl[12] = '{1'b0, 1'b1, 8'h85, mk(1,0,1,0,0,0,8'd2,32'h4,32'h3409_000F)};
        tbl[13] = '{1'b0, 1'b0, 8'h00, mk(0,0,0,1,0,1,8'd2,32'h4,32'h3409_000F)};

        // Reset state
        reset         = 1'b0;
        Start         = 1'b0;
        bus.ByteValid = 1'b0;
        bus.ByteData  = 8'h00;
        #1;
        check("reset_outputs", outs(), 78'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Scenario 1: gapless load, checked cycle by cycle
        clear_log();
        x0 = xfers;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            Start         = tbl[i].start;
            bus.ByteValid = tbl[i].valid;
            bus.ByteData  = tbl[i].data;
            #1;
            check($sformatf("s1_row%0d", i), outs(), tbl[i].exp);
        end
        check("s1_xfers", 78'(xfers - x0), 78'(10));
        check_log("s1");

        // Scenario 2: bad checksum still writes both words
        clear_log();
        pulse_start();
        send_stream(s_bad, 1'b0);
        @(negedge clk);
        bus.ByteValid = 1'b0;
        #1;
        check("s2_final", outs(), mk(0,0,0,0,1,0,8'd2,32'h4,32'h3409_000F));
        check_log("s2");

        // Scenario 3: illegal headers 00 and 21
        for (int h = 0; h < 2; h++) begin
            clear_log();
            pulse_start();
            send_byte((h == 0) ? 8'h00 : 8'h21);
            @(negedge clk);
            bus.ByteValid = 1'b1;
            bus.ByteData  = 8'h05;
            #1;
            check($sformatf("s3_hdr%0d_err", h), outs(),
                  mk(0,0,0,0,1,0,8'd0,32'h4,32'h3409_000F));
            idle(3);
            #1;
            check($sformatf("s3_hdr%0d_nowrite", h), 78'(wr_addr.size()), 78'(0));
            check($sformatf("s3_hdr%0d_ready", h), 78'(bus.ByteReady), 78'(0));
        end

        // Scenario 4: random gaps, ByteValid held across each WRITE
        clear_log();
        pulse_start();
        x0 = xfers;
        send_stream(s_good, 1'b1);
        @(negedge clk);
        bus.ByteValid = 1'b0;
        #1;
        check("s4_final", outs(), mk(0,0,0,1,0,1,8'd2,32'h4,32'h3409_000F));
        check("s4_xfers", 78'(xfers - x0), 78'(10));
        check_log("s4");

        // Scenario 5: restart after one word plus two bytes
        clear_log();
        pulse_start();
        for (int i = 0; i < 7; i++) send_byte(s_good[i]);
        @(negedge clk);
        Start         = 1'b1;
        bus.ByteValid = 1'b1;
        bus.ByteData  = 8'hAA;
        #1;
        check("s5_start_ready", 78'(bus.ByteReady), 78'(0));
        x0 = xfers;
        @(posedge clk);
        #1;
        Start         = 1'b0;
        bus.ByteValid = 1'b0;
        #1;
        check("s5_start_noxfer", 78'(xfers - x0), 78'(0));
        check("s5_after_start", outs(), mk(1,0,1,0,0,0,8'd0,32'h0,32'h2008_0005));
        clear_log();
        send_stream(s_good, 1'b0);
        @(negedge clk);
        bus.ByteValid = 1'b0;
        #1;
        check("s5_final", outs(), mk(0,0,0,1,0,1,8'd2,32'h4,32'h3409_000F));
        check_log("s5");

        // Scenario 6: asynchronous reset mid-DATA
        pulse_start();
        send_byte(8'h02);
        send_byte(8'h20);
        send_byte(8'h08);
        @(negedge clk);
        bus.ByteValid = 1'b1;
        bus.ByteData  = 8'h00;
        #1;
        reset = 1'b0;
        #1;
        check("s6_async_reset", outs(), 78'd0);
        x0 = xfers;
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("s6_idle_after_release", outs(), 78'd0);
        check("s6_no_xfer", 78'(xfers - x0), 78'(0));
        pulse_start();
        bus.ByteValid = 1'b0;
        #1;
        check("s6_start_busy", 78'(Busy), 78'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/program_memory_loader.md
# program_memory_loader

Boot-time loader that receives a byte stream over a valid/ready handshake and writes it as 32-bit instruction words into the processor's program memory. It is the write side of the instruction-fetch path: the processor only reads program memory, and this block fills it. It holds the processor in reset until a complete, checksum-valid image is stored. It sits between the host byte source (serial bridge or testbench) and the write port of the program RAM that replaces the ROM.

## Interface
- MEMORY_DEPTH, 32, number of 32-bit words in program memory; legal range 1..255.
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- Start  in  1  single-cycle pulse; begins a new load from any state.
- ByteData  in  8  stream byte.
- ByteValid  in  1  ByteData is valid.
- ByteReady  out  1  loader accepts a byte this cycle. A byte transfers on a rising edge where ByteValid && ByteReady.
- MemWrite  out  1  one-cycle write strobe to program RAM.
- MemAddress  out  32  byte address of the word being written; always a multiple of 4.
- MemWriteData  out  32  word being written.
- ProcessorRun  out  1  high only in DONE; drives the processor's active-low reset.
- Busy  out  1  high in HEADER, DATA, WRITE, CHECK.
- Done  out  1  high in DONE.
- Error  out  1  high in ERROR.
- WordsLoaded  out  8  number of words written in the current load.

## Operation
- Stream format: header byte N (word count), then 4·N data bytes, then 1 checksum byte.
- Data bytes are big-endian: the first byte of each word goes to bits 31:24.
- The 8-bit sum of the header, all data bytes, and the checksum must be 0x00 (mod 256).
- States and transitions:
  - IDLE: waits for Start, then goes to HEADER.
  - HEADER: accepts N. If N==0 or N>MEMORY_DEPTH, goes to ERROR. Otherwise goes to DATA.
  - DATA: accepts bytes into a shift register with a 2-bit byte counter. On acceptance of the 4th byte, goes to WRITE.
  - WRITE: MemWrite=1 for exactly one cycle with MemAddress = 4·word index and MemWriteData = the assembled word. Then increments the word index and WordsLoaded. If the word index now equals N, goes to CHECK; else goes to DATA.
  - CHECK: accepts the checksum byte. If the sum is 0, goes to DONE; else goes to ERROR.
  - DONE: ProcessorRun=1 and Done=1 until Start.
  - ERROR: Error=1 and ProcessorRun=0 until Start.
- ByteReady = 1 in HEADER, DATA, CHECK, and only when Start=0. It is 0 in all other states.
- The running 8-bit sum accumulates every accepted byte and wraps modulo 256.
- Start from any state does the following on the next edge:
  - clears the sum, byte counter, word index, WordsLoaded, Done, and Error;
  - drops ProcessorRun;
  - goes to HEADER.
  - Partially assembled bytes are discarded. Words already written remain in RAM.
- Start has priority over byte acceptance in the same cycle: no byte transfers.
- MemAddress and MemWriteData are registered and hold their last written value outside WRITE.

## Timing
- Reset values (applied asynchronously while reset=0):
  - state IDLE;
  - ByteReady, MemWrite, ProcessorRun, Busy, Done, Error = 0;
  - MemAddress, MemWriteData, WordsLoaded = 0.
- Reset asserted mid-operation aborts immediately with no completing write. After release the block stays in IDLE until Start.
- Latency per word: 4 accepted bytes plus 1 WRITE cycle. A gapless stream therefore costs 5 cycles per word.
- ByteReady is low during WRITE. A byte held with ByteValid=1 across WRITE must not be dropped or duplicated; it is accepted on the first DATA/CHECK edge.
- DONE/ERROR are entered on the edge after the checksum byte is accepted. ProcessorRun rises in that same cycle.
- ERROR from a bad header is entered on the edge after the header is accepted. No MemWrite occurs in that case.
- The last word is written to address 4·(N−1). With N==MEMORY_DEPTH the index never exceeds the depth.

## Test plan
1. Release reset, pulse Start, send gapless stream 02 20 08 00 05 34 09 00 0F 85.
   - Required: writes 0x20080005@0x00, then 0x3409000F@0x04, each with a one-cycle MemWrite.
   - Then Done=1, ProcessorRun=1, WordsLoaded=2, Error=0.
2. Same stream with checksum 84.
   - Required: both writes still occur; Error=1, ProcessorRun=0, Done=0.
3. Header 00, and separately header 21 with MEMORY_DEPTH=32.
   - Required: ERROR one edge after the header, MemWrite never asserted, ByteReady=0 afterwards.
4. Stream from scenario 1 with random ByteValid gaps, ByteValid held high across each WRITE cycle.
   - Required: identical writes and final state; exactly 10 transfers counted.
5. After 1 word plus 2 bytes, pulse Start (with ByteValid=1 that cycle), then send the full scenario-1 stream.
   - Required: no byte accepted in the Start cycle; final writes match scenario 1; WordsLoaded=2.
6. Assert reset mid-DATA.
   - Required: all outputs 0 immediately, with no clock needed; after release stays IDLE, ignoring ByteValid, until Start.
